// File: rtl/program_counter_stack.sv
// Program counter with a subroutine return-address stack and a sticky fault state.
// Latency: every PC/stack update lands on the clock edge after the request; all outputs are registered or register-decoded.
// Backpressure: none; enable=0 holds all state, and FAULT ignores everything except clear_fault.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   enable             operate this cycle (RUN only)
//   load_n             active-low jump: PC <= address
//   call               push PC+INCREMENT_STEP, then PC <= address
//   ret                pop the top entry into PC (wins over call)
//   clear_fault        clear the sticky flags and leave FAULT
//   address            jump/call target
//   data               current PC
//   stack_depth        number of valid return-address entries
//   stack_full/empty   decoded from stack_depth
//   overflow/underflow sticky: CALL while full / RET while empty
//   fault              high while in the FAULT state
//
// Build option: define PC_STACK_TRAP_EN to vector the PC to TRAP_VECTOR on a
// stack overflow/underflow (stack flushed, block stays in RUN) instead of
// freezing in FAULT.

module program_counter_stack #(
  parameter int unsigned                 ADDRESS_WIDTH  = 16,
  parameter int unsigned                 STACK_DEPTH    = 8,
  parameter int unsigned                 INCREMENT_STEP = 1,
  parameter logic [ADDRESS_WIDTH-1:0]    TRAP_VECTOR    = ADDRESS_WIDTH'(16'h00F0)
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               load_n,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               clear_fault,
  input  logic [ADDRESS_WIDTH-1:0]           address,
  output logic [ADDRESS_WIDTH-1:0]           data,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               overflow,
  output logic                               underflow,
  output logic                               fault
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W   = $clog2(STACK_DEPTH);

`ifdef PC_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  // Registered state
  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [DEPTH_W-1:0]       r_depth;
  logic                     r_ovf;
  logic                     r_unf;
  logic [ADDRESS_WIDTH-1:0] r_stack [STACK_DEPTH];

  // Next-state values
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] w_pc_nxt;
  logic [DEPTH_W-1:0]       w_depth_nxt;
  logic                     w_ovf_nxt;
  logic                     w_unf_nxt;
  logic                     w_push;

  // Helper decodes
  logic [ADDRESS_WIDTH-1:0] w_pc_inc;
  logic [IDX_W-1:0]         w_top_idx;
  logic [IDX_W-1:0]         w_push_idx;
  logic                     w_is_full;
  logic                     w_is_empty;

  // Natural truncation gives the modulo-2^ADDRESS_WIDTH wrap with no flag.
  assign w_pc_inc   = r_pc + ADDRESS_WIDTH'(INCREMENT_STEP);
  // The top entry sits at depth-1; only read when depth>0.
  assign w_top_idx  = IDX_W'(r_depth - DEPTH_W'(1));
  // The next free slot is at depth; only written when depth<STACK_DEPTH.
  assign w_push_idx = IDX_W'(r_depth);
  assign w_is_full  = (r_depth == DEPTH_W'(STACK_DEPTH));
  assign w_is_empty = (r_depth == '0);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decisions
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;

    unique case (r_state)
      ST_RUN: begin
        // Clearing is evaluated first so a fault raised in the same cycle
        // still leaves its sticky flag set.
        if (clear_fault) begin
          w_ovf_nxt = 1'b0;
          w_unf_nxt = 1'b0;
        end

        if (enable) begin
          if (ret) begin
            // ret outranks call; a simultaneous call is silently dropped.
            if (!w_is_empty) begin
              w_pc_nxt    = r_stack[w_top_idx];
              w_depth_nxt = r_depth - DEPTH_W'(1);
            end else begin
              w_unf_nxt = 1'b1;
              if (TRAP_EN) begin
                w_pc_nxt    = TRAP_VECTOR;
                w_depth_nxt = '0;
              end else begin
                w_state_nxt = ST_FAULT;
              end
            end
          end else if (call) begin
            if (!w_is_full) begin
              w_push      = 1'b1;
              w_pc_nxt    = address;
              w_depth_nxt = r_depth + DEPTH_W'(1);
            end else begin
              w_ovf_nxt = 1'b1;
              if (TRAP_EN) begin
                w_pc_nxt    = TRAP_VECTOR;
                w_depth_nxt = '0;
              end else begin
                w_state_nxt = ST_FAULT;
              end
            end
          end else if (!load_n) begin
            w_pc_nxt = address;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end

      ST_FAULT: begin
        // PC and stack stay frozen; only clear_fault is honoured.
        if (clear_fault) begin
          w_ovf_nxt   = 1'b0;
          w_unf_nxt   = 1'b0;
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // PC, depth and sticky flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_depth <= w_depth_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // Return-address storage. Contents are don't-care after reset: depth is
  // cleared, so nothing written under reset can ever be popped.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  // Outputs straight from registers or simple register decodes
  assign data        = r_pc;
  assign stack_depth = r_depth;
  assign stack_full  = w_is_full;
  assign stack_empty = w_is_empty;
  assign overflow    = r_ovf;
  assign underflow   = r_unf;
  assign fault       = (r_state == ST_FAULT);

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack (default parameters).
// Directed scenarios followed by randomized traffic against a queue-based model.
// Each sampled output is compared with an immediate assertion.

module tb_program_counter_stack;

  localparam int unsigned AW   = 16;
  localparam int unsigned SD   = 8;
  localparam int unsigned STEP = 1;
  localparam int unsigned TRAP = 32'h00F0;
  localparam int unsigned MASK = (1 << AW) - 1;

`ifdef PC_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          clock;
  logic          reset_n;
  logic          enable;
  logic          load_n;
  logic          call;
  logic          ret;
  logic          clear_fault;
  logic [AW-1:0] address;
  logic [AW-1:0] data;
  logic [3:0]    stack_depth;
  logic          stack_full;
  logic          stack_empty;
  logic          overflow;
  logic          underflow;
  logic          fault;

  int checks = 0;
  int errors = 0;

  // Reference model: PC as an integer, stack as a LIFO queue.
  int unsigned m_pc;
  int unsigned m_stk[$];
  bit          m_ovf;
  bit          m_unf;
  bit          m_fault;

  program_counter_stack dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .load_n      (load_n),
    .call        (call),
    .ret         (ret),
    .clear_fault (clear_fault),
    .address     (address),
    .data        (data),
    .stack_depth (stack_depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .overflow    (overflow),
    .underflow   (underflow),
    .fault       (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":data"},      32'(data),        m_pc);
    chk({tag, ":depth"},     32'(stack_depth), m_stk.size());
    chk({tag, ":full"},      32'(stack_full),  32'(m_stk.size() == SD));
    chk({tag, ":empty"},     32'(stack_empty), 32'(m_stk.size() == 0));
    chk({tag, ":overflow"},  32'(overflow),    32'(m_ovf));
    chk({tag, ":underflow"}, 32'(underflow),   32'(m_unf));
    chk({tag, ":fault"},     32'(fault),       32'(m_fault));
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
    m_fault = 0;
  endtask

  task automatic stack_error();
    if (TRAP_EN) begin
      m_pc = TRAP;
      m_stk.delete();
    end else begin
      m_fault = 1;
    end
  endtask

  task automatic model_step(input bit en, input bit ln, input bit c, input bit r,
                            input bit cf, input int unsigned a);
    if (m_fault) begin
      if (cf) begin
        m_ovf = 0;
        m_unf = 0;
        m_fault = 0;
      end
      return;
    end
    if (cf) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (!en) return;
    if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_unf = 1;
        stack_error();
      end
    end else if (c) begin
      if (m_stk.size() < SD) begin
        m_stk.push_back((m_pc + STEP) & MASK);
        m_pc = a & MASK;
      end else begin
        m_ovf = 1;
        stack_error();
      end
    end else if (!ln) begin
      m_pc = a & MASK;
    end else begin
      m_pc = (m_pc + STEP) & MASK;
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input string tag, input bit en, input bit ln, input bit c,
                      input bit r, input bit cf, input logic [AW-1:0] a);
    @(negedge clock);
    enable = en; load_n = ln; call = c; ret = r; clear_fault = cf; address = a;
    model_step(en, ln, c, r, cf, 32'(a));
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [AW-1:0] a;
    bit en, ln, c, r, cf;

    enable = 0; load_n = 1; call = 0; ret = 0; clear_fault = 0; address = '0;
    reset_n = 0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clock);
    reset_n = 1;

    // Plain increment 0 -> 4
    for (int i = 0; i < 4; i++) step("incr", 1, 1, 0, 0, 0, '0);
    chk("incr_to_4", 32'(data), 32'd4);

    // Asynchronous reset mid-cycle with a call pending
    @(negedge clock);
    enable = 1; call = 1; address = 16'h0abc;
    #2;
    reset_n = 0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clock);
    #1;
    check_all("reset_held");
    @(negedge clock);
    reset_n = 1; call = 0; enable = 0;

    // Reach PC=5, then call/ret
    for (int i = 0; i < 5; i++) step("to5", 1, 1, 0, 0, 0, '0);
    step("call40", 1, 1, 1, 0, 0, 16'h0040);
    chk("call40_pc", 32'(data), 32'h40);
    step("ret6", 1, 1, 0, 1, 0, '0);
    chk("ret6_pc", 32'(data), 32'd6);

    // Fill the stack, overflow, ignored load, clear, unwind LIFO
    for (int i = 0; i < SD; i++) step("nest", 1, 1, 1, 0, 0, AW'($urandom));
    step("overflow", 1, 1, 1, 0, 0, 16'h7777);
    step("fault_load", 1, 0, 0, 0, 0, 16'h2222);
    step("fault_ret", 1, 1, 0, 1, 0, 16'h0000);
    step("clear_ovf", 0, 1, 0, 0, 1, '0);
    for (int i = 0; i < SD; i++) step("unwind", 1, 1, 0, 1, 0, '0);

    // Underflow at PC=0x0010
    step("load10", 1, 0, 0, 0, 0, 16'h0010);
    step("underflow", 1, 1, 0, 1, 0, '0);
    chk("underflow_pc", 32'(data), TRAP_EN ? TRAP : 32'h10);
    step("clear_unf", 0, 1, 0, 0, 1, '0);

    // Wrap at the top of the address space
    step("loadffff", 1, 0, 0, 0, 0, 16'hffff);
    step("wrap", 1, 1, 0, 0, 0, '0);
    chk("wrap_pc", 32'(data), 32'h0);

    // Simultaneous call+ret at depth 2
    step("callA", 1, 1, 1, 0, 0, 16'h0100);
    step("callB", 1, 1, 1, 0, 0, 16'h0200);
    step("call_ret", 1, 1, 1, 1, 0, 16'h0300);
    chk("call_ret_pc", 32'(data), 32'h0101);

    // enable=0 holds even with a jump requested
    for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 0, 0, 16'h1234);
    step("jump1234", 1, 0, 0, 0, 0, 16'h1234);
    chk("jump_pc", 32'(data), 32'h1234);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      r  = ($urandom_range(0, 4) == 0);
      c  = ($urandom_range(0, 3) == 0);
      ln = ($urandom_range(0, 5) != 0);
      cf = ($urandom_range(0, 11) == 0);
      a  = AW'($urandom);
      step("rand", en, ln, c, r, cf, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
Parametrised successor to counter_w_load, used as the program counter. Adds a subroutine return-address stack (CALL/RET), a sticky fault state, and configurable width, depth and increment step. The block sits between the execution driver and the memory controller. It takes its jump target from the decision unit and drives the program-RAM fetch address.

Parameters:
ADDRESS_WIDTH, 16, width of the PC, the jump target and each stack entry
STACK_DEPTH, 8, number of return-address entries; must be ≥2
INCREMENT_STEP, 1, value added to the PC per enabled advance
TRAP_VECTOR, 16'h00F0, PC value loaded on a stack fault when PC_STACK_TRAP_EN is defined

Ports:
clock  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  advance/operate this cycle; the block holds when low
load_n  input  1  active-low jump; PC <= address
call  input  1  push PC+INCREMENT_STEP, then PC <= address
ret  input  1  pop the top entry into PC
clear_fault  input  1  leave FAULT, clear the sticky flags
address  input  ADDRESS_WIDTH  jump/call target
data  output  ADDRESS_WIDTH  current PC
stack_depth  output  $clog2(STACK_DEPTH+1)  number of valid entries
stack_full  output  1  stack_depth == STACK_DEPTH
stack_empty  output  1  stack_depth == 0
overflow  output  1  sticky: CALL issued while full
underflow  output  1  sticky: RET issued while empty
fault  output  1  high while in the FAULT state

Behaviour:
- Reset (async, reset_n low), applied immediately:
  - data=0, stack_depth=0, stack_empty=1, stack_full=0
  - overflow=0, underflow=0, fault=0, state=RUN
  - stack contents don't-care
- All other updates occur on the rising edge of clock.
- FSM states: RUN, FAULT.
- RUN, enable=0: all state holds. call/ret/load_n are ignored.
- RUN, enable=1: one operation per cycle, in priority order ret > call > load_n==0 > increment.
  - ret with depth>0: PC <= top entry; depth-1. Latency 1 cycle.
  - call with depth<STACK_DEPTH:
    - stack[depth] <= PC+INCREMENT_STEP, computed modulo 2^ADDRESS_WIDTH
    - PC <= address; depth+1
  - load_n==0: PC <= address. The stack is unchanged.
  - Otherwise: PC <= PC+INCREMENT_STEP, wrapping modulo 2^ADDRESS_WIDTH. Max value wraps to 0 with no flag.
- Boundary: call while full:
  - no push; overflow<=1
  - without the macro: PC holds and the next state is FAULT
- Boundary: ret while empty:
  - depth stays 0; underflow<=1
  - without the macro: PC holds and the next state is FAULT
- Simultaneous call+ret: ret wins. call is dropped with no push and no flag.
- FAULT:
  - PC and stack frozen; enable, load_n, call and ret all ignored
  - fault=1
  - clear_fault=1 on a clock edge: overflow=underflow=0, state=RUN. PC and stack keep their values.
- clear_fault in RUN clears the sticky flags only; it has no other effect.
- Outputs are registered or decoded from registers only. There is no combinational path from the inputs to data.
- Reset asserted mid-operation overrides everything, including a pending push.

Optional Feature:
- Macro: PC_STACK_TRAP_EN.
- Defined: on an overflow or underflow the block sets the sticky flag and loads PC <= TRAP_VECTOR. It clears depth to 0 (stack_empty=1) and stays in RUN; fault stays 0. clear_fault still clears the sticky flags.
- Undefined: fault behaviour is exactly as described in Behaviour (enter FAULT, PC holds).

Test Plan:
- Reset then 4 cycles with enable=1 and INCREMENT_STEP=1 -> data 0,1,2,3,4; stack_empty=1. Assert reset_n low mid-cycle -> data=0 immediately, before the next clock edge.
- PC=5, call with address=16'h0040 -> data=16'h0040, depth=1, stack[0]=6. Then ret -> data=6, depth=0, stack_empty=1.
- Nested: 8 calls (STACK_DEPTH=8) -> stack_full=1. A 9th call -> overflow=1, fault=1, data unchanged, and load_n is ignored. Then clear_fault -> fault=0, depth still 8. Then 8 rets return the addresses in LIFO order.
- ret while empty at PC=16'h0010 -> underflow=1, fault=1, data=16'h0010. With PC_STACK_TRAP_EN defined -> data=16'h00F0, fault=0, underflow=1.
- PC=16'hFFFF with enable=1 -> data=16'h0000 and no flags. Same cycle call+ret at depth=2 -> ret wins: depth=1, PC=popped value.
- enable=0 with load_n=0 and address=16'h1234 -> data holds for 3 cycles. Then enable=1 -> data=16'h1234.
